// File: rtl/dm_cache_ctrl.sv
// -----------------------------------------------------------------------------
// dm_cache_ctrl
//   Read-only direct-mapped cache placed in front of the instruction-address
//   processor. Every cycle spent in LOOKUP treats addr as a new request. A hit
//   answers with a one-cycle rvalid strobe on the following cycle. A miss fetches
//   the whole line from main memory through a req/ack handshake followed by
//   WORDS_PER_LINE beat-valid transfers, then answers the same way. Saturating
//   hit/miss counters are kept for performance reporting.
//
// Ports
//   clk         sole clock, rising edge
//   rst         synchronous, active-high reset
//   addr        processor byte address, [0:31] with bit 0 = MSB
//   data        read data, valid while rvalid = 1
//   rvalid      one-cycle response strobe
//   mem_req     line-fill request, held until mem_ack
//   mem_addr    line-aligned byte address of the fill
//   mem_ack     one-cycle acceptance of mem_req
//   mem_rdata   fill beat data
//   mem_rvalid  fill beat strobe, beats arrive in ascending word order
//   hit_cnt     saturating hit count
//   miss_cnt    saturating miss count
// -----------------------------------------------------------------------------
module dm_cache_ctrl #(
    parameter int NUM_LINES      = 8,
    parameter int WORDS_PER_LINE = 4,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [0:31]      addr,
    output logic [31:0]      data,
    output logic             rvalid,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    input  logic             mem_ack,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_rvalid,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int OFF_W   = $clog2(WORDS_PER_LINE);
    localparam int IDX_W   = $clog2(NUM_LINES);
    localparam int TAG_LSB = 2 + OFF_W + IDX_W;
    localparam int TAG_W   = 32 - TAG_LSB;

    typedef enum logic [1:0] {LOOKUP, RESP, MREQ, FILL} state_t;

    state_t state, next_state;

    // Numeric view of the processor address: the ascending port range maps
    // positionally, so addr_v[31] is the MSB and addr_v[0] the LSB.
    logic [31:0] addr_v;
    assign addr_v = addr;

    logic unused_byte_off;
    assign unused_byte_off = ^addr_v[1:0];

    logic [OFF_W-1:0] off_in, off_q, beat_q;
    logic [IDX_W-1:0] idx_in, idx_q;
    logic [TAG_W-1:0] tag_in, tag_q;

    assign off_in = addr_v[2 +: OFF_W];
    assign idx_in = addr_v[2 + OFF_W +: IDX_W];
    assign tag_in = addr_v[TAG_LSB +: TAG_W];

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [31:0]          data_mem [NUM_LINES][WORDS_PER_LINE];

    logic        hit;
    logic        beat_last;
    logic        fill_beat;
    logic [31:0] resp_word;

    assign hit       = valid_q[idx_in] && (tag_mem[idx_in] == tag_in);
    assign beat_last = (beat_q == OFF_W'(WORDS_PER_LINE - 1));
    assign fill_beat = (state == FILL) && mem_rvalid;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            LOOKUP:  next_state = hit ? RESP : MREQ;
            RESP:    next_state = LOOKUP;
            MREQ:    if (mem_ack) next_state = FILL;
            FILL:    if (mem_rvalid && beat_last) next_state = RESP;
            default: next_state = LOOKUP;
        endcase
    end

    // Word loaded into data on the edge that enters RESP. When a fill
    // completes, the requested word is either the beat arriving right now
    // (last word of the line) or one already written by an earlier beat.
    always_comb begin
        resp_word = data_mem[idx_in][off_in];
        if (state == FILL) begin
            resp_word = (off_q == beat_q) ? mem_rdata : data_mem[idx_q][off_q];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= LOOKUP;
        else     state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= '0;
            rvalid   <= 1'b0;
            data     <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
            beat_q   <= '0;
            off_q    <= '0;
            idx_q    <= '0;
            tag_q    <= '0;
        end else begin
            rvalid  <= (next_state == RESP);
            mem_req <= (next_state == MREQ);
            if (next_state == RESP) data <= resp_word;

            unique case (state)
                LOOKUP: begin
                    off_q <= off_in;
                    idx_q <= idx_in;
                    tag_q <= tag_in;
                    if (hit) begin
                        if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
                    end else begin
                        if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
                        mem_addr <= {addr_v[31:2 + OFF_W], {(2 + OFF_W){1'b0}}};
                    end
                end
                MREQ: begin
                    // The line is being replaced: drop it now so a partial
                    // fill can never produce a hit.
                    if (mem_ack) begin
                        beat_q         <= '0;
                        valid_q[idx_q] <= 1'b0;
                    end
                end
                FILL: begin
                    if (mem_rvalid) begin
                        beat_q <= beat_q + OFF_W'(1);
                        if (beat_last) valid_q[idx_q] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: tag and data arrays are deliberately not reset; valid_q alone
    // decides whether a line's contents mean anything, so plain RAM suffices.
    always_ff @(posedge clk) begin
        if (!rst && fill_beat) begin
            data_mem[idx_q][beat_q] <= mem_rdata;
            if (beat_last) tag_mem[idx_q] <= tag_q;
        end
    end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dm_cache_ctrl
//   Directed + randomized bench for dm_cache_ctrl. The bench plays both the
//   processor and main memory. Expected results come from a line-level model:
//   a map of which line-aligned address each index currently holds, a read-only
//   memory function, and plain hit/miss tallies clipped at the counter maximum.
// -----------------------------------------------------------------------------
module tb_dm_cache_ctrl;

    localparam int NUM_LINES  = 8;
    localparam int WPL        = 4;
    localparam int CNT_W      = 3;
    localparam int LINE_BYTES = WPL * 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [0:31]      addr;
    logic [31:0]      data;
    logic             rvalid;
    logic             mem_req;
    logic [31:0]      mem_addr;
    logic             mem_ack;
    logic [31:0]      mem_rdata;
    logic             mem_rvalid;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;

    dm_cache_ctrl #(
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WPL),
        .CNT_W          (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .data       (data),
        .rvalid     (rvalid),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit          m_valid [NUM_LINES];
    logic [31:0] m_line  [NUM_LINES];
    int          m_hits;
    int          m_misses;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = a & ~32'h3;
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic int sat(input int n);
        return (n > CNT_MAX) ? CNT_MAX : n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_LINES; i++) m_valid[i] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    // Hold reset for two edges, optionally with stray fill beats on the bus,
    // and check every reset value. Returns with the next edge a lookup edge.
    task automatic do_reset(input bit stale);
        rst        = 1'b1;
        addr       = 32'h0;
        mem_ack    = 1'b0;
        mem_rvalid = stale;
        mem_rdata  = $urandom;
        @(negedge clk);
        mem_rdata  = $urandom;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("rst_rvalid",   rvalid,   0);
        check("rst_data",     data,     0);
        check("rst_mem_req",  mem_req,  0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_hit_cnt",  hit_cnt,  0);
        check("rst_miss_cnt", miss_cnt, 0);
        rst = 1'b0;
        model_reset();
    endtask

    // One processor request. Precondition: the next rising edge is a lookup
    // edge. Plays memory on a miss with ack_dly stall cycles and random beat
    // gaps. noise drives ignored mem_ack/mem_rvalid activity where the
    // controller must not react to it.
    task automatic access(input logic [31:0] a, input int ack_dly, input bit noise);
        logic [31:0] line_a;
        int          idx;
        bit          exp_hit;
        line_a  = a & ~(LINE_BYTES - 1);
        idx     = (a / LINE_BYTES) % NUM_LINES;
        exp_hit = m_valid[idx] && (m_line[idx] == line_a);

        addr       = a;
        mem_ack    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rvalid = noise;
        mem_rdata  = $urandom;
        @(negedge clk);
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;

        if (exp_hit) begin
            m_hits++;
            check("hit_rvalid",  rvalid,  1);
            check("hit_data",    data,    mem_word(a));
            check("hit_no_req",  mem_req, 0);
        end else begin
            m_misses++;
            check("miss_rvalid",   rvalid,   0);
            check("miss_req",      mem_req,  1);
            check("miss_mem_addr", mem_addr, line_a);
            for (int s = 0; s < ack_dly; s++) begin
                mem_rvalid = noise;
                mem_rdata  = $urandom;
                @(negedge clk);
                check("stall_req",  mem_req,  1);
                check("stall_addr", mem_addr, line_a);
            end
            mem_rvalid = 1'b0;
            mem_ack    = 1'b1;
            @(negedge clk);
            mem_ack = 1'b0;
            check("req_drop", mem_req, 0);
            for (int b = 0; b < WPL; b++) begin
                repeat ($urandom_range(0, 2)) begin
                    mem_rdata = $urandom;
                    @(negedge clk);
                    check("fill_no_rvalid", rvalid, 0);
                end
                mem_rvalid = 1'b1;
                mem_rdata  = mem_word(line_a + 32'(4 * b));
                @(negedge clk);
                mem_rvalid = 1'b0;
            end
            check("fill_rvalid", rvalid, 1);
            check("fill_data",   data,   mem_word(a));
            m_valid[idx] = 1'b1;
            m_line[idx]  = line_a;
        end
        check("hit_cnt",  hit_cnt,  sat(m_hits));
        check("miss_cnt", miss_cnt, sat(m_misses));
        @(negedge clk);
        check("strobe_len", rvalid, 0);
    endtask

    logic [31:0] table_a [10];
    logic [31:0] base;

    initial begin
        rst        = 1'b1;
        addr       = 32'h0;
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;

        // Cold miss, then same-line hits
        do_reset(1'b0);
        access(32'h0000_0040, 2, 1'b0);
        access(32'h0000_0044, 0, 1'b0);
        access(32'h0000_0048, 0, 1'b0);
        access(32'h0000_004C, 0, 1'b0);
        check("t2_hit_cnt", hit_cnt, 3);

        // Conflict on one index: every access replaces the line
        do_reset(1'b0);
        access(32'h0000_0040, 1, 1'b0);
        access(32'h0000_00C0, 0, 1'b0);
        access(32'h0000_0040, 3, 1'b0);
        check("t3_miss_cnt", miss_cnt, 3);

        // Processor loop: ten entries inside one cache-sized window, so the
        // second pass (and the wrap back to entry 0) hits throughout.
        do_reset(1'b0);
        base = 32'($urandom_range(0, 255)) * 32'(NUM_LINES * LINE_BYTES);
        for (int i = 0; i < 10; i++) table_a[i] = base + 32'($urandom_range(0, 31) * 4);
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 10; i++) access(table_a[i], $urandom_range(0, 3), 1'b1);
        end
        access(table_a[0], 0, 1'b1);

        // Random traffic over a 1 KB region: mixed hits, misses and conflicts
        for (int i = 0; i < 60; i++) begin
            access(32'($urandom_range(0, 255) * 4), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // Reset after two of four beats, stale beats around and after reset
        do_reset(1'b0);
        addr = 32'h0000_0120;
        @(negedge clk);
        check("t5_req", mem_req, 1);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        for (int b = 0; b < 2; b++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_word(32'h0000_0120 + 32'(4 * b));
            @(negedge clk);
        end
        do_reset(1'b1);
        access(32'h0000_012C, 3, 1'b1);
        access(32'h0000_0120, 0, 1'b0);
        access(32'h0000_0124, 0, 1'b0);

        // Long ack stall, then counter saturation at 7
        do_reset(1'b0);
        access(32'h0000_0300, 50, 1'b0);
        for (int i = 0; i < 9; i++) access(32'h0000_0300 + 32'(4 * (i % WPL)), 0, 1'b0);
        check("t6_hit_sat", hit_cnt, 7);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
